// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide unit: bus widths, iteration
// count, funct codes and small decode helpers.
package mult_div_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned FUNCT_W       = 6;
    localparam int unsigned MULT_DIV_BUS  = 64;
    localparam int unsigned MULT_DIV_ITER = 32;

    localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
    localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
    localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
    localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_kind_e;

    // True for any funct code that launches a multiply or divide
    function automatic logic is_mult_div(input logic [FUNCT_W-1:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

    // True for the two divide codes
    function automatic logic is_div(input logic [FUNCT_W-1:0] f);
        return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
    endfunction

    // True for the signed variants
    function automatic logic is_signed_op(input logic [FUNCT_W-1:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_DIV);
    endfunction

    // Magnitude of a word; only signed operations take the absolute value
    function automatic logic [WORD_W-1:0] magnitude(input logic [WORD_W-1:0] v,
                                                    input logic             sgn);
        return (sgn && v[WORD_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mult_div.sv
// Iterative 32x32 multiply / 32/32 divide unit. Multiply is radix-2
// shift-add, divide is restoring; both run 32 iterations over one shared
// 64-bit shift register, then one cycle of sign correction.
module mult_div
    import mult_div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FUNCT_W-1:0]      funct,
    input  logic [WORD_W-1:0]       operand_1,
    input  logic [WORD_W-1:0]       operand_2,
    input  logic                    flush,
    input  logic                    hold,
    output logic                    done,
    output logic [MULT_DIV_BUS-1:0] result,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e                  state_q,   state_d;
    logic [4:0]              cnt_q,     cnt_d;
    op_kind_e                kind_q,    kind_d;
    logic                    sgn_q,     sgn_d;
    logic                    res_neg_q, res_neg_d;
    logic                    rem_neg_q, rem_neg_d;
    logic [MULT_DIV_BUS-1:0] acc_q,     acc_d;
    logic [WORD_W-1:0]       opb_q,     opb_d;
    logic [MULT_DIV_BUS-1:0] result_q,  result_d;

    logic                    start;
    logic                    div_zero;
    logic                    last_iter;
    logic [WORD_W:0]         mul_sum;
    logic [WORD_W:0]         div_rem;
    logic [WORD_W+1:0]       div_diff;
    logic [MULT_DIV_BUS-1:0] fixed;

    // Start / divide-by-zero decode from the EX-stage funct and operands
    always_comb begin
        start     = is_mult_div(funct) && !flush;
        div_zero  = is_div(funct) && (operand_2 == '0);
        last_iter = (cnt_q == 5'(MULT_DIV_ITER - 1));
    end

    // State register; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush returns to IDLE from any state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = div_zero ? S_DONE : S_BUSY;
            S_BUSY: if (last_iter) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (!hold) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // Status outputs decoded from the current state
    always_comb begin
        done = (state_q == S_DONE);
        busy = (state_q == S_BUSY) || (state_q == S_FIX);
    end

    // Datapath: operand capture, one shift-add / restoring step per BUSY
    // cycle, sign fix-up into the result register in FIX
    always_comb begin
        cnt_d     = cnt_q;
        kind_d    = kind_q;
        sgn_d     = sgn_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        result_d  = result_q;

        // Multiply: acc = {partial product, remaining multiplier bits}
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        // Divide: acc = {partial remainder, remaining dividend / quotient bits}
        div_rem  = {acc_q[63:32], acc_q[31]};
        div_diff = {1'b0, div_rem} - {2'b00, opb_q};

        fixed = acc_q;
        if (kind_q == OP_MULT) begin
            if (sgn_q && res_neg_q) fixed = ~acc_q + 64'd1;
        end else begin
            if (sgn_q && res_neg_q) fixed[31:0]  = ~acc_q[31:0] + 32'd1;
            if (sgn_q && rem_neg_q) fixed[63:32] = ~acc_q[63:32] + 32'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    kind_d    = is_div(funct) ? OP_DIV : OP_MULT;
                    sgn_d     = is_signed_op(funct);
                    res_neg_d = operand_1[31] ^ operand_2[31];
                    rem_neg_d = operand_1[31];
                    cnt_d     = '0;
                    acc_d     = {32'd0, magnitude(operand_1, is_signed_op(funct))};
                    opb_d     = magnitude(operand_2, is_signed_op(funct));
                    if (div_zero) result_d = {operand_1, 32'hFFFF_FFFF};
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 5'd1;
                if (kind_q == OP_MULT) begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end else if (div_diff[33]) begin
                    acc_d = {div_rem[31:0], acc_q[30:0], 1'b0};
                end else begin
                    acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                end
            end
            S_FIX:  result_d = fixed;
            default: ;
        endcase

        // A flushed operation never reaches the result register
        if (flush) result_d = result_q;
    end

    // Datapath registers; all cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            kind_q    <= OP_MULT;
            sgn_q     <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            acc_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            kind_q    <= kind_d;
            sgn_q     <= sgn_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: a latency/arithmetic reference model
// compared every cycle, plus directed operations with literal expectations.
module tb_mult_div;
    import mult_div_pkg::*;

    localparam int LAT = 34;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  funct;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        flush;
    logic        hold;
    logic        done;
    logic [63:0] result;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    mult_div dut (
        .clk       (clk),
        .rst       (rst),
        .funct     (funct),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .flush     (flush),
        .hold      (hold),
        .done      (done),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Arithmetic reference straight from the instruction semantics
    function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        if ((f == FUNCT_DIV || f == FUNCT_DIVU) && b == 32'd0) return {a, 32'hFFFF_FFFF};
        case (f)
            FUNCT_MULT:  return sa * sb;
            FUNCT_MULTU: return ua * ub;
            FUNCT_DIV: begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                q = ua / ub;
                r = ua % ub;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic bit ref_is_op(input logic [5:0] f);
        return f == FUNCT_MULT || f == FUNCT_MULTU || f == FUNCT_DIV || f == FUNCT_DIVU;
    endfunction

    // Behavioural model: an accepted op shows done LAT cycles after start
    // (1 cycle for divide-by-zero), busy in between, result held otherwise
    bit          m_valid = 0;
    bit          m_busy, m_done;
    int          m_elapsed;
    logic [63:0] m_pending, m_result;

    always @(posedge clk) begin
        m_valid <= 1'b1;
        if (rst) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_result <= '0;
        end else if (flush) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else if (m_done) begin
            if (!hold) m_done <= 1'b0;
        end else if (m_busy) begin
            m_elapsed <= m_elapsed + 1;
            if (m_elapsed + 1 == LAT) begin
                m_busy   <= 1'b0;
                m_done   <= 1'b1;
                m_result <= m_pending;
            end
        end else if (ref_is_op(funct)) begin
            if ((funct == FUNCT_DIV || funct == FUNCT_DIVU) && operand_2 == 32'd0) begin
                m_done   <= 1'b1;
                m_result <= ref_result(funct, operand_1, operand_2);
            end else begin
                m_busy    <= 1'b1;
                m_elapsed <= 1;
                m_pending <= ref_result(funct, operand_1, operand_2);
            end
        end
    end

    // Every-cycle comparison against the model, away from the clock edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_done",   {63'd0, done}, {63'd0, m_done});
            check("model_busy",   {63'd0, busy}, {63'd0, m_busy});
            check("model_result", result, m_result);
        end
    end

    // Issue one op at the current negedge; junk non-mult/div funct and
    // scrambled operands after the start cycle
    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int hold_n, input int flush_at, input bit chk,
                         input logic [63:0] exp, input int exp_lat, input string nm);
        int lat;
        bit flushed;
        funct     = f;
        operand_1 = a;
        operand_2 = b;
        hold      = (hold_n > 0);
        flush     = 1'b0;
        @(negedge clk);
        funct     = 6'($urandom_range(0, 23));
        operand_1 = $urandom;
        operand_2 = $urandom;
        lat       = 1;
        flushed   = 0;
        while (!done && lat < 40 && !flushed) begin
            if (flush_at != 0 && lat == flush_at) begin
                flush = 1'b1;
                @(negedge clk);
                flush   = 1'b0;
                flushed = 1;
                if (chk) begin
                    check({nm, "_flush_done"}, {63'd0, done}, 64'd0);
                    check({nm, "_flush_busy"}, {63'd0, busy}, 64'd0);
                end
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        if (flushed) begin
            hold = 1'b0;
        end else begin
            if (!done) check({nm, "_timeout"}, 64'd0, 64'd1);
            if (chk) begin
                check({nm, "_result"}, result, exp);
                check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
            end
            repeat (hold_n) begin
                @(negedge clk);
                if (chk) check({nm, "_hold"}, {63'd0, done} ^ 64'd1 | (result ^ exp), 64'd0);
            end
            hold = 1'b0;
            @(negedge clk);
            if (chk) check({nm, "_released"}, {63'd0, done}, 64'd0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0] ops [4];
        ops[0] = FUNCT_MULT;
        ops[1] = FUNCT_MULTU;
        ops[2] = FUNCT_DIV;
        ops[3] = FUNCT_DIVU;

        rst = 1'b1; funct = '0; operand_1 = '0; operand_2 = '0; flush = 1'b0; hold = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_done",   {63'd0, done}, 64'd0);
        check("reset_busy",   {63'd0, busy}, 64'd0);
        check("reset_result", result, 64'd0);
        rst = 1'b0;

        do_op(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 64'hFFFF_FFFE_0000_0001, LAT, "multu_max");
        do_op(FUNCT_MULT,  32'hFFFF_FFFD, 32'd7,         0, 0, 1, 64'hFFFF_FFFF_FFFF_FFEB, LAT, "mult_neg");
        do_op(FUNCT_MULT,  32'h8000_0000, 32'h8000_0000, 0, 0, 1, 64'h4000_0000_0000_0000, LAT, "mult_minsq");
        do_op(FUNCT_DIV,   32'hFFFF_FFF9, 32'd2,         0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFD, LAT, "div_neg");
        do_op(FUNCT_DIVU,  32'd7,         32'd2,         0, 0, 1, 64'h0000_0001_0000_0003, LAT, "divu_7_2");
        do_op(FUNCT_DIVU,  32'd100,       32'd0,         0, 0, 1, 64'h0000_0064_FFFF_FFFF, 1,   "divu_zero");
        do_op(FUNCT_DIV,   32'hFFFF_FFF9, 32'd0,         2, 0, 1, 64'hFFFF_FFF9_FFFF_FFFF, 1,   "div_zero");
        do_op(FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 64'h0000_0000_8000_0000, LAT, "div_ovf");
        do_op(FUNCT_DIVU,  32'd1000,      32'd7,         5, 0, 1, 64'h0000_0006_0000_008E, LAT, "divu_hold");
        do_op(FUNCT_MULT,  32'd12345,     32'd678,       0, 10, 1, 64'd0, LAT, "mult_flush");
        do_op(FUNCT_DIVU,  32'd9,         32'd3,         0, 0, 1, 64'h0000_0000_0000_0003, LAT, "divu_9_3");

        // Reset in cycle 20 of a divide
        funct = FUNCT_DIV; operand_1 = 32'd5000; operand_2 = 32'd7;
        @(negedge clk);
        funct = '0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_done",   {63'd0, done}, 64'd0);
        check("rst_mid_result", result, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, b;
            a = pick();
            b = ($urandom % 8 == 0) ? 32'd0 : pick();
            do_op(ops[$urandom % 4], a, b, int'($urandom % 4),
                  ($urandom % 10 == 0) ? int'($urandom_range(1, 35)) : 0,
                  0, 64'd0, 0, "rand");
            repeat ($urandom % 3) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 No parameters; all widths come from the shared bus/funct include files.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 funct  in  6  funct field held in EX; FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV and FUNCT_DIVU start an operation.
REQ-005 operand_1  in  32  rs value; multiplicand or dividend.
REQ-006 operand_2  in  32  rt value; multiplier or divisor.
REQ-007 flush  in  1  pipeline flush; cancels any operation.
REQ-008 hold  in  1  downstream stall; keeps the completed result presented.
REQ-009 done  out  1  result valid; drives EX mult_div_done.
REQ-010 result  out  64  {HI,LO}; MULT_DIV_BUS width; drives EX mult_div_result.
REQ-011 busy  out  1  high in BUSY or FIX.

Function
REQ-012 FSM states: IDLE, BUSY, FIX, DONE.
REQ-013 IDLE -> BUSY when funct is a mult/div code, flush=0 and the divide is not by zero; on entry:
- latch op kind and signedness
- latch |operand_1| and |operand_2|; absolute value only for signed ops
- latch result sign = op1[31]^op2[31]
- latch remainder sign = op1[31]
- clear the 5-bit iteration counter
REQ-014 BUSY performs one iteration per cycle for exactly 32 cycles, then moves to FIX.
REQ-015 Multiply uses radix-2 shift-add over a 64-bit accumulator (unsigned magnitudes).
REQ-016 Divide uses restoring division: 32-bit quotient and 33-bit partial remainder, unsigned magnitudes.
REQ-017 FIX applies sign correction in one cycle, then moves to DONE:
- signed MULT: two's-complement negate the 64-bit product when the result sign is 1
- signed DIV: negate the quotient when the result sign is 1; negate the remainder when the remainder sign is 1
REQ-018 Result packing: mult gives result = 64-bit product; div gives result[63:32] = remainder (HI), result[31:0] = quotient (LO).
REQ-019 Divide by zero: IDLE -> DONE directly, result = {operand_1, 32'hFFFFFFFF}; applies to both DIV and DIVU.
REQ-020 Latency:
- start cycle is cycle 0 (IDLE with a valid op)
- done=1 first in cycle 34
- divide-by-zero: done=1 first in cycle 1
REQ-021 done=1 only in DONE; result holds its final value throughout DONE.
REQ-022 DONE -> IDLE on the first cycle with hold=0; DONE stays while hold=1.
REQ-023 Back-to-back ops: IDLE after DONE accepts a new op in the very next cycle, so the same EX instruction never restarts.
REQ-024 flush=1 in any state -> IDLE next edge with done=0 and no result update; flush beats start in IDLE.
REQ-025 Operands and funct are sampled only at start; changes during BUSY/FIX are ignored.
REQ-026 Non-mult/div funct in IDLE: stay IDLE, done=0, result unchanged.
REQ-027 Corner cases SHALL follow the arithmetic above with no special handling:
- signed DIV 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0
- MULT 0x80000000 * 0x80000000 gives 0x40000000_00000000

Reset
REQ-028 rst=1 at a clock edge forces state IDLE, done=0, busy=0, result=0, counter=0, internal registers=0.
REQ-029 rst overrides flush and start and aborts any in-flight operation.
REQ-030 The first op is accepted in the first cycle with rst=0.

Structure
REQ-031 Shared include files:
- funct.v holds the FUNCT_MULT/MULTU/DIV/DIVU codes
- bus.v holds MULT_DIV_BUS and a new MULT_DIV_ITER (32)
REQ-032 State encodings stay local to the module.
REQ-033 Single module; no sub-module, because multiply and divide share the shift register and counter.
REQ-034 Top-level wiring:
- EX stall_request already equals !done during mult/div
- the hazard unit drives hold and flush

Verification
REQ-035 MULTU 0xFFFFFFFF * 0xFFFFFFFF -> done in cycle 34, result 0xFFFFFFFE_00000001.
REQ-036 MULT -3 * 7 -> result 0xFFFFFFFF_FFFFFFEB; then MULT 0x80000000 * 0x80000000 back-to-back -> 0x40000000_00000000.
REQ-037 DIV -7 / 2 -> result 0xFFFFFFFF_FFFFFFFD (HI = -1, LO = -3); DIVU 7 / 2 -> 0x00000001_00000003.
REQ-038 DIVU 100 / 0 -> done in cycle 1, result 0x00000064_FFFFFFFF.
REQ-039 MULT started, flush in cycle 10 -> done never asserts, IDLE next cycle; a following DIVU 9 / 3 gives 0x00000000_00000003.
REQ-040 hold=1 for 5 cycles at DONE -> done and result stable 6 cycles, then IDLE; rst in cycle 20 of a DIV -> done=0 and result=0 next cycle.
